// File: rtl/edge_detector_multi.sv
// edge_detector_multi: synchronise, debounce and edge-detect raw inputs,
// then gate edges by mode into sticky flags and a saturating counter.
module edge_detector_multi #(
   parameter int CHANNELS    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   entrada,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   evt_clr,
   input  logic                  cnt_clr,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   rise_pulse,
   output logic [CHANNELS-1:0]   fall_pulse,
   output logic [CHANNELS-1:0]   evt_pending,
   output logic [CNT_W-1:0]      evt_count
);

   localparam int DW = $clog2(DEBOUNCE) + 1;
   localparam int PW = $clog2(CHANNELS + 1);
   localparam int SW = CNT_W + PW;
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
   localparam logic [SW-1:0] CMAX = SW'({CNT_W{1'b1}});

   logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CHANNELS-1:0][DW-1:0]          dcnt_q, dcnt_d;
   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;
   logic [CHANNELS-1:0] pend_q, pend_d;
   logic [CHANNELS-1:0] ge;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]       pop;
   logic [SW-1:0]       base, sum;

   // Shift each raw input one stage deeper; last stage is the clean sample.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], entrada[c]};
         s[c]      = sync_q[c][SYNC_STAGES-1];
      end
   end

   // Accept a new level only after DEBOUNCE consecutive differing samples.
   always_comb begin
      dcnt_d  = dcnt_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (s[c] == level_q[c]) begin
            dcnt_d[c] = '0;
         end else if (dcnt_q[c] == DMAX) begin
            dcnt_d[c]  = '0;
            level_d[c] = s[c];
            rise_d[c]  = s[c];
            fall_d[c]  = ~s[c];
         end else begin
            dcnt_d[c] = dcnt_q[c] + 1'b1;
         end
      end
   end

   // Gate pulses by mode, update sticky flags and the clipped counter.
   always_comb begin
      ge  = '0;
      pop = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         ge[c] = (rise_q[c] & mode[2*c]) | (fall_q[c] & mode[2*c+1]);
         pop   = pop + PW'(ge[c]);
      end
      pend_d = (pend_q & ~evt_clr) | ge;
      base   = cnt_clr ? '0 : SW'(cnt_q);
      sum    = base + SW'(pop);
      cnt_d  = (sum > CMAX) ? '1 : sum[CNT_W-1:0];
   end

   // Synchroniser and debounce state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         dcnt_q  <= '0;
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
      end else begin
         sync_q  <= sync_d;
         dcnt_q  <= dcnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Event flags and counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign level       = level_q;
   assign rise_pulse  = rise_q;
   assign fall_pulse  = fall_q;
   assign evt_pending = pend_q;
   assign evt_count   = cnt_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb_edge_detector_multi: random and directed stimulus with a queued
// reference model checked by an independent negedge monitor.
module tb_edge_detector_multi;

   localparam int CH = 2;
   localparam int SS = 2;
   localparam int DB = 4;

   typedef struct {
      logic [1:0] lv;
      logic [1:0] rp;
      logic [1:0] fp;
      logic [1:0] ep;
      logic [7:0] cnt;
   } snap_t;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [1:0] entrada = '0;
   logic [3:0] mode    = '0;
   logic [1:0] evt_clr = '0;
   logic       cnt_clr = 1'b0;
   logic [1:0] level, rise_pulse, fall_pulse, evt_pending;
   logic [7:0] evt_count;

   int total = 0;
   int bad   = 0;

   snap_t sb[$];

   bit         hist[CH][$];
   int         run[CH];
   logic [1:0] m_lv, m_rp, m_fp, m_pend, m_ge;
   int         m_cnt, m_ev, m_tmp;
   bit         sv;

   edge_detector_multi #(
      .CHANNELS(CH), .SYNC_STAGES(SS),
      .DEBOUNCE(DB), .CNT_W(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .entrada(entrada), .mode(mode),
      .evt_clr(evt_clr), .cnt_clr(cnt_clr),
      .level(level), .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .evt_pending(evt_pending),
      .evt_count(evt_count)
   );

   always #5 clk = ~clk;

   function automatic snap_t cur_model();
      snap_t e;
      e.lv  = m_lv;
      e.rp  = m_rp;
      e.fp  = m_fp;
      e.ep  = m_pend;
      e.cnt = 8'(m_cnt);
      return e;
   endfunction

   // Reference model: delay line, run-length debounce, gated events.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            repeat (SS) hist[c].push_back(1'b0);
            run[c] = 0;
         end
         m_lv = '0; m_rp = '0; m_fp = '0;
         m_pend = '0; m_cnt = 0;
         sb.delete();
         sb.push_back(cur_model());
      end else begin
         m_ev = 0;
         for (int c = 0; c < CH; c++) begin
            m_ge[c] = (m_rp[c] && mode[2*c]) ||
                      (m_fp[c] && mode[2*c+1]);
            m_ev += int'(m_ge[c]);
         end
         m_pend = (m_pend & ~evt_clr) | m_ge;
         m_tmp  = (cnt_clr ? 0 : m_cnt) + m_ev;
         m_cnt  = (m_tmp > 255) ? 255 : m_tmp;
         for (int c = 0; c < CH; c++) begin
            sv = hist[c].pop_front();
            hist[c].push_back(entrada[c]);
            m_rp[c] = 1'b0;
            m_fp[c] = 1'b0;
            if (sv != m_lv[c]) begin
               run[c]++;
               if (run[c] == DB) begin
                  m_lv[c] = sv;
                  run[c]  = 0;
                  if (sv) m_rp[c] = 1'b1;
                  else    m_fp[c] = 1'b1;
               end
            end else begin
               run[c] = 0;
            end
         end
         sb.push_back(cur_model());
      end
   end

   // Monitor: pop one expected snapshot per cycle and compare.
   always @(negedge clk) begin
      snap_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL sb_empty t=%0t", $time);
      end else begin
         e = sb.pop_front();
         if ({level, rise_pulse, fall_pulse, evt_pending, evt_count} !==
             {e.lv, e.rp, e.fp, e.ep, e.cnt}) begin
            bad++;
            $display("FAIL sb t=%0t got lv=%b r=%b f=%b p=%b c=%0d want lv=%b r=%b f=%b p=%b c=%0d",
                     $time, level, rise_pulse, fall_pulse,
                     evt_pending, evt_count,
                     e.lv, e.rp, e.fp, e.ep, e.cnt);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   initial begin
      cyc(3);
      rst_n = 1'b1;

      // random phase with one mid-run reset
      for (int i = 0; i < 1200; i++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 5) == 0) entrada[c] = ~entrada[c];
         if (i % 64 == 0) mode = 4'($urandom);
         evt_clr = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
         cnt_clr = ($urandom_range(0, 39) == 0);
         if (i == 600) rst_n = 1'b0;
         if (i == 603) rst_n = 1'b1;
         cyc(1);
      end
      evt_clr = '0;
      cnt_clr = 1'b0;

      // reset mid-bounce, then clean restart
      entrada = 2'b00;
      mode    = 4'b1111;
      cyc(10);
      entrada = 2'b11;
      cyc(3);
      rst_n = 1'b0;
      #1;
      chk("rst_level", 32'(level), 0);
      chk("rst_pend", 32'(evt_pending), 0);
      chk("rst_cnt", 32'(evt_count), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(5);
      chk("rel_lvl_e5", 32'(level), 0);
      cyc(1);
      chk("rel_lvl_e6", 32'(level), 3);
      chk("rel_rise_e6", 32'(rise_pulse), 3);
      cyc(1);
      chk("rel_rise_e7", 32'(rise_pulse), 0);

      // glitch rejection
      entrada = 2'b00;
      cyc(10);
      evt_clr = 2'b11;
      cnt_clr = 1'b1;
      cyc(1);
      evt_clr = '0;
      cnt_clr = 1'b0;
      entrada = 2'b01;
      cyc(3);
      entrada = 2'b00;
      cyc(10);
      chk("glitch_lvl", 32'(level), 0);
      chk("glitch_pend", 32'(evt_pending), 0);
      chk("glitch_cnt", 32'(evt_count), 0);

      // per-channel modes
      mode    = 4'b1001;
      entrada = 2'b11;
      cyc(10);
      entrada = 2'b00;
      cyc(10);
      chk("mode_pend", 32'(evt_pending), 3);
      chk("mode_cnt", 32'(evt_count), 2);

      // clear racing a set
      evt_clr = 2'b11;
      cyc(1);
      evt_clr = '0;
      mode    = 4'b0001;
      entrada = 2'b01;
      cyc(6);
      evt_clr = 2'b01;
      cyc(1);
      chk("race_set_wins", 32'(evt_pending[0]), 1);
      cyc(1);
      chk("race_cleared", 32'(evt_pending[0]), 0);
      evt_clr = '0;

      // saturation
      mode = 4'b1111;
      cyc(10);
      cnt_clr = 1'b1;
      cyc(1);
      cnt_clr = 1'b0;
      for (int k = 0; k < 127; k++) begin
         entrada = ~entrada;
         cyc(8);
      end
      chk("sat_254", 32'(evt_count), 254);
      entrada = ~entrada;
      cyc(8);
      chk("sat_255", 32'(evt_count), 255);
      entrada = ~entrada;
      cyc(8);
      chk("sat_hold", 32'(evt_count), 255);
      entrada[0] = ~entrada[0];
      cyc(6);
      cnt_clr = 1'b1;
      cyc(1);
      cnt_clr = 1'b0;
      chk("clr_plus_evt", 32'(evt_count), 1);

      // off mode
      cyc(4);
      mode    = 4'b0000;
      evt_clr = 2'b11;
      cnt_clr = 1'b1;
      cyc(1);
      evt_clr = '0;
      cnt_clr = 1'b0;
      for (int i = 0; i < 300; i++) begin
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 7) == 0) entrada[c] = ~entrada[c];
         cyc(1);
      end
      cyc(10);
      chk("off_pend", 32'(evt_pending), 0);
      chk("off_cnt", 32'(evt_count), 0);

      cyc(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
